// File: rtl/uart_boot_loader.sv
// uart_boot_loader
//   Boot handshake between the CPU-side UART pair and the core. After reset it
//   sends SYNC_BYTE, then receives a 4-byte little-endian program size and the
//   image. It packs the image into 32-bit little-endian words for instruction
//   memory and sends DONE_BYTE. It then releases the core (cpu_run) and passes
//   the UART through to the core. Any framing error or oversize image sends
//   ERR_BYTE and holds boot_err until reset.
//
//   Build option: define BOOT_CHECKSUM_EN to expect one extra byte after the
//   image. That byte must equal the 8-bit wrapping sum of all image bytes.
//
// Ports
//   clk, reset_n          clock, synchronous active-low reset
//   rx_data/rx_valid      received byte and its 1-cycle strobe
//   rx_ferr               framing error, qualified by rx_valid
//   tx_busy               UART_TX busy
//   tx_start/tx_data      start strobe and byte to UART_TX (loader, then core)
//   cpu_tx_start/_data    core TX request, honoured only after release
//   cpu_rx_valid          rx_valid forwarded to the core after release
//   imem_we/addr/wdata    instruction memory write port (word addressed)
//   cpu_run               core release, sticky until reset
//   boot_err              boot failure flag, sticky until reset
module uart_boot_loader #(
    parameter int unsigned IMEM_AW   = 10,
    parameter logic [7:0]  SYNC_BYTE = 8'h99,
    parameter logic [7:0]  DONE_BYTE = 8'hAA,
    parameter logic [7:0]  ERR_BYTE  = 8'hEE
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [7:0]         rx_data,
    input  logic               rx_valid,
    input  logic               rx_ferr,
    input  logic               tx_busy,
    output logic               tx_start,
    output logic [7:0]         tx_data,
    input  logic               cpu_tx_start,
    input  logic [7:0]         cpu_tx_data,
    output logic               cpu_rx_valid,
    output logic               imem_we,
    output logic [IMEM_AW-1:0] imem_addr,
    output logic [31:0]        imem_wdata,
    output logic               cpu_run,
    output logic               boot_err
);

    // Largest image that fits: 4 bytes per word, 2**IMEM_AW words.
    localparam logic [32:0] MAX_BYTES = 33'd4 << IMEM_AW;

    typedef enum logic [2:0] {
        SEND_SYNC,
        RECV_SIZE,
        RECV_DATA,
        FLUSH,
        SEND_DONE,
        RUN,
        ERROR
`ifdef BOOT_CHECKSUM_EN
        , RECV_SUM
`endif
    } state_t;

    state_t              state_q, state_d;
    logic                tx_start_q, tx_start_d;
    logic [7:0]          tx_data_q, tx_data_d;
    logic                guard_q;
    logic                imem_we_q, imem_we_d;
    logic [IMEM_AW-1:0]  imem_addr_q, imem_addr_d;
    logic [31:0]         imem_wdata_q, imem_wdata_d;
    logic                cpu_run_q, cpu_run_d;
    logic                boot_err_q, boot_err_d;
    logic                err_sent_q, err_sent_d;
    logic [31:0]         size_q, size_d;
    logic [1:0]          size_idx_q, size_idx_d;
    logic [31:0]         cnt_q, cnt_d;
    logic [31:0]         wbuf_q, wbuf_d;
`ifdef BOOT_CHECKSUM_EN
    logic [7:0]          sum_q, sum_d;
`endif

    logic                can_tx;
    logic                rx_ok;
    logic                rx_bad;
    logic [31:0]         size_full;
    logic [31:0]         cnt_inc;
    logic [1:0]          lane;

    always_comb begin
        // A new start waits for an idle transmitter and for the cycle after a
        // pulse (guard) so a slow tx_busy rise cannot let a second start through.
        can_tx    = !tx_busy && !tx_start_q && !guard_q;
        rx_ok     = rx_valid && !rx_ferr;
        rx_bad    = rx_valid && rx_ferr;
        size_full = {rx_data, size_q[31:8]};
        cnt_inc   = cnt_q + 32'd1;
        lane      = cnt_q[1:0];

        state_d      = state_q;
        tx_start_d   = 1'b0;
        tx_data_d    = tx_data_q;
        imem_we_d    = 1'b0;
        imem_addr_d  = imem_addr_q;
        imem_wdata_d = imem_wdata_q;
        cpu_run_d    = cpu_run_q;
        boot_err_d   = boot_err_q;
        err_sent_d   = err_sent_q;
        size_d       = size_q;
        size_idx_d   = size_idx_q;
        cnt_d        = cnt_q;
        wbuf_d       = wbuf_q;
`ifdef BOOT_CHECKSUM_EN
        sum_d        = sum_q;
`endif

        case (state_q)
            SEND_SYNC: begin
                if (can_tx) begin
                    tx_start_d = 1'b1;
                    tx_data_d  = SYNC_BYTE;
                    state_d    = RECV_SIZE;
                end
            end

            RECV_SIZE: begin
                if (rx_bad) begin
                    state_d    = ERROR;
                    boot_err_d = 1'b1;
                end else if (rx_ok) begin
                    // Bytes arrive LSB first; shift in from the top.
                    size_d     = size_full;
                    size_idx_d = size_idx_q + 2'd1;
                    cnt_d      = '0;
                    if (size_idx_q == 2'd3) begin
                        if (size_full == '0) begin
                            state_d = SEND_DONE;
                        end else if ({1'b0, size_full} > MAX_BYTES) begin
                            state_d    = ERROR;
                            boot_err_d = 1'b1;
                        end else begin
                            state_d = RECV_DATA;
                        end
                    end
                end
            end

            RECV_DATA: begin
                if (rx_bad) begin
                    state_d    = ERROR;
                    boot_err_d = 1'b1;
                end else if (rx_ok) begin
                    wbuf_d[{lane, 3'b000} +: 8] = rx_data;
                    cnt_d = cnt_inc;
`ifdef BOOT_CHECKSUM_EN
                    sum_d = sum_q + rx_data;
`endif
                    if (lane == 2'd3) begin
                        imem_we_d    = 1'b1;
                        imem_addr_d  = cnt_q[IMEM_AW+1:2];
                        imem_wdata_d = wbuf_d;
                        wbuf_d       = '0;
                    end
                    if (cnt_inc == size_q) begin
`ifdef BOOT_CHECKSUM_EN
                        state_d = RECV_SUM;
`else
                        state_d = FLUSH;
`endif
                    end
                end
            end

`ifdef BOOT_CHECKSUM_EN
            RECV_SUM: begin
                if (rx_bad) begin
                    state_d    = ERROR;
                    boot_err_d = 1'b1;
                end else if (rx_ok) begin
                    if (rx_data == sum_q) begin
                        state_d = FLUSH;
                    end else begin
                        state_d    = ERROR;
                        boot_err_d = 1'b1;
                    end
                end
            end
`endif

            FLUSH: begin
                // Unused upper lanes are already zero: the buffer is cleared
                // after every full word.
                if (size_q[1:0] != 2'd0) begin
                    imem_we_d    = 1'b1;
                    imem_addr_d  = cnt_q[IMEM_AW+1:2];
                    imem_wdata_d = wbuf_q;
                end
                state_d = SEND_DONE;
            end

            SEND_DONE: begin
                if (can_tx) begin
                    tx_start_d = 1'b1;
                    tx_data_d  = DONE_BYTE;
                    state_d    = RUN;
                end
            end

            RUN: begin
                // The DONE pulse is on the wire during the first RUN cycle;
                // release the core on the following cycle.
                cpu_run_d = 1'b1;
            end

            ERROR: begin
                boot_err_d = 1'b1;
                if (!err_sent_q && can_tx) begin
                    tx_start_d = 1'b1;
                    tx_data_d  = ERR_BYTE;
                    err_sent_d = 1'b1;
                end
            end

            default: begin
                state_d = SEND_SYNC;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q      <= SEND_SYNC;
            tx_start_q   <= 1'b0;
            tx_data_q    <= '0;
            guard_q      <= 1'b0;
            imem_we_q    <= 1'b0;
            imem_addr_q  <= '0;
            imem_wdata_q <= '0;
            cpu_run_q    <= 1'b0;
            boot_err_q   <= 1'b0;
            err_sent_q   <= 1'b0;
            size_q       <= '0;
            size_idx_q   <= '0;
            cnt_q        <= '0;
            wbuf_q       <= '0;
`ifdef BOOT_CHECKSUM_EN
            sum_q        <= '0;
`endif
        end else begin
            state_q      <= state_d;
            tx_start_q   <= tx_start_d;
            tx_data_q    <= tx_data_d;
            guard_q      <= tx_start_q;
            imem_we_q    <= imem_we_d;
            imem_addr_q  <= imem_addr_d;
            imem_wdata_q <= imem_wdata_d;
            cpu_run_q    <= cpu_run_d;
            boot_err_q   <= boot_err_d;
            err_sent_q   <= err_sent_d;
            size_q       <= size_d;
            size_idx_q   <= size_idx_d;
            cnt_q        <= cnt_d;
            wbuf_q       <= wbuf_d;
`ifdef BOOT_CHECKSUM_EN
            sum_q        <= sum_d;
`endif
        end
    end

    // Loader TX is registered; after release the core drives TX combinationally.
    assign tx_start     = cpu_run_q ? cpu_tx_start : tx_start_q;
    assign tx_data      = cpu_run_q ? cpu_tx_data  : tx_data_q;
    assign cpu_rx_valid = rx_valid & cpu_run_q;
    assign imem_we      = imem_we_q;
    assign imem_addr    = imem_addr_q;
    assign imem_wdata   = imem_wdata_q;
    assign cpu_run      = cpu_run_q;
    assign boot_err     = boot_err_q;

endmodule

// File: tb/tb_uart_boot_loader.sv
// Testbench for uart_boot_loader: randomized boots checked by a scoreboard
// against an image-level reference model.
module tb_uart_boot_loader;

    localparam int unsigned AW   = 10;
    localparam int unsigned MAXB = 4 << AW;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic [7:0]    rx_data = '0;
    logic          rx_valid = 1'b0;
    logic          rx_ferr = 1'b0;
    logic          tx_busy = 1'b0;
    logic          tx_start;
    logic [7:0]    tx_data;
    logic          cpu_tx_start = 1'b0;
    logic [7:0]    cpu_tx_data = '0;
    logic          cpu_rx_valid;
    logic          imem_we;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_wdata;
    logic          cpu_run;
    logic          boot_err;

    always #5 clk = ~clk;

    uart_boot_loader #(.IMEM_AW(AW)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .rx_ferr      (rx_ferr),
        .tx_busy      (tx_busy),
        .tx_start     (tx_start),
        .tx_data      (tx_data),
        .cpu_tx_start (cpu_tx_start),
        .cpu_tx_data  (cpu_tx_data),
        .cpu_rx_valid (cpu_rx_valid),
        .imem_we      (imem_we),
        .imem_addr    (imem_addr),
        .imem_wdata   (imem_wdata),
        .cpu_run      (cpu_run),
        .boot_err     (boot_err)
    );

    int unsigned checks   = 0;
    int unsigned failures = 0;

    logic [7:0]    exp_tx[$];
    logic [AW-1:0] exp_addr[$];
    logic [31:0]   exp_word[$];
    logic [7:0]    exp_rx[$];
    logic [7:0]    img[$];
    bit            run_exp = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    // Word idx of the image, little-endian, bytes at or beyond nbytes are zero.
    function automatic logic [31:0] word_of(input int unsigned idx, input int unsigned nbytes);
        logic [31:0] w;
        w = 0;
        for (int unsigned k = 0; k < 4; k++)
            if (4 * idx + k < nbytes) w = w + (32'(img[4 * idx + k]) << (8 * k));
        return w;
    endfunction

    function automatic logic [7:0] image_sum(input int unsigned nbytes);
        int unsigned s;
        s = 0;
        for (int unsigned i = 0; i < nbytes; i++) s = s + img[i];
        return 8'(s % 256);
    endfunction

    // Monitor: pops expectations whenever the DUT presents an output; also acts
    // as the UART_TX model, raising tx_busy one cycle after each start.
    initial begin
        int unsigned busy_cnt;
        bit          busy_pend;
        bit          aa_seen;
        logic [7:0]  e8;
        busy_cnt  = 0;
        busy_pend = 1'b0;
        forever begin
            @(negedge clk);
            aa_seen = 1'b0;
            if (!reset_n) begin
                busy_cnt  = 0;
                busy_pend = 1'b0;
                tx_busy   = 1'b0;
                run_exp   = 1'b0;
            end else begin
                check("cpu_run_timing", cpu_run, run_exp);
                if (imem_we) begin
                    if (exp_word.size() == 0) check("imem_we_unexpected", imem_we, 0);
                    else begin
                        check("imem_addr", imem_addr, exp_addr.pop_front());
                        check("imem_wdata", imem_wdata, exp_word.pop_front());
                    end
                end
                if (cpu_rx_valid) begin
                    if (exp_rx.size() == 0) check("cpu_rx_valid_unexpected", cpu_rx_valid, 0);
                    else check("cpu_rx_byte", rx_data, exp_rx.pop_front());
                end
                if (tx_start) begin
                    if (!cpu_run) check("tx_start_while_busy", tx_busy, 0);
                    if (exp_tx.size() == 0) check("tx_start_unexpected", tx_start, 0);
                    else begin
                        e8 = exp_tx.pop_front();
                        check("tx_data", tx_data, e8);
                        if (!cpu_run && e8 == 8'hAA) aa_seen = 1'b1;
                    end
                    busy_pend = 1'b1;
                end else if (busy_pend) begin
                    busy_pend = 1'b0;
                    busy_cnt  = $urandom_range(1, 6);
                end else if (busy_cnt != 0) begin
                    busy_cnt--;
                end
                tx_busy = (busy_cnt != 0) || busy_pend;
                if (aa_seen) run_exp = 1'b1;
            end
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic wait_drain(input string name);
        int unsigned n;
        n = 0;
        while ((exp_tx.size() + exp_word.size() + exp_rx.size()) != 0 && n < 3000) begin
            @(posedge clk);
            n++;
        end
        check(name, exp_tx.size() + exp_word.size() + exp_rx.size(), 0);
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        reset_n = 1'b0; rx_valid = 1'b0; rx_ferr = 1'b0; cpu_tx_start = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        check("rst_tx_start", tx_start, 0);
        check("rst_tx_data", tx_data, 0);
        check("rst_imem_we", imem_we, 0);
        check("rst_imem_addr", imem_addr, 0);
        check("rst_imem_wdata", imem_wdata, 0);
        check("rst_cpu_run", cpu_run, 0);
        check("rst_boot_err", boot_err, 0);
        exp_tx.delete(); exp_addr.delete(); exp_word.delete(); exp_rx.delete();
        exp_tx.push_back(8'h99);
        reset_n = 1'b1;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit ferr, input int unsigned gap);
        @(posedge clk); #1;
        rx_data = b; rx_valid = 1'b1; rx_ferr = ferr;
        @(posedge clk); #1;
        rx_valid = 1'b0; rx_ferr = 1'b0; rx_data = 8'($urandom);
        repeat (gap) @(posedge clk);
    endtask

    // One complete boot from reset using the bytes in img.
    task automatic boot(input logic [31:0] size, input int ferr_at, input bit bad_sum, input int unsigned gap);
        bit          ok;
        int unsigned nsend;
        bit          stop;
        do_reset();
        wait_drain("sync_byte_sent");
        if (size == 0) begin
            ok = 1'b1;
            exp_tx.push_back(8'hAA);
        end else if (size > MAXB) begin
            ok = 1'b0;
            exp_tx.push_back(8'hEE);
        end else begin
            nsend = (ferr_at >= 0) ? int'(ferr_at) : size;
            for (int unsigned i = 0; i < nsend / 4; i++) begin
                exp_addr.push_back(AW'(i));
                exp_word.push_back(word_of(i, size));
            end
            ok = (ferr_at < 0) && !bad_sum;
            if (ok && (size % 4) != 0) begin
                exp_addr.push_back(AW'(size / 4));
                exp_word.push_back(word_of(size / 4, size));
            end
            exp_tx.push_back(ok ? 8'hAA : 8'hEE);
        end
        for (int i = 0; i < 4; i++) send_byte(size[8 * i +: 8], 1'b0, gap);
        if (size != 0 && size <= MAXB) begin
            stop = 1'b0;
            for (int i = 0; i < int'(size) && !stop; i++) begin
                if (i == ferr_at) begin
                    send_byte(img[i], 1'b1, gap);
                    stop = 1'b1;
                end else begin
                    send_byte(img[i], 1'b0, gap);
                end
            end
`ifdef BOOT_CHECKSUM_EN
            if (!stop) send_byte(image_sum(size) + (bad_sum ? 8'd1 : 8'd0), 1'b0, gap);
`endif
        end
        wait_drain("boot_outputs");
        check("final_cpu_run", cpu_run, ok);
        check("final_boot_err", boot_err, !ok);
    endtask

    task automatic run_checks();
        @(posedge clk); #1;
        exp_tx.push_back(8'h50);
        cpu_tx_data = 8'h50; cpu_tx_start = 1'b1;
        #1;
        check("run_tx_start", tx_start, 1);
        check("run_tx_data", tx_data, 8'h50);
        @(posedge clk); #1;
        cpu_tx_start = 1'b0;
        exp_rx.push_back(8'h41);
        send_byte(8'h41, 1'b0, 0);
        wait_drain("run_passthrough");
    endtask

    task automatic random_image(input int unsigned n);
        img.delete();
        for (int unsigned i = 0; i < n; i++) img.push_back(8'($urandom));
    endtask

    initial begin
        int unsigned n;

        img = {8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
        boot(32'd8, -1, 1'b0, 1);
        run_checks();

        img = {8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
        boot(32'd5, -1, 1'b0, 2);

        img.delete();
        boot(32'd0, -1, 1'b0, 0);
        run_checks();

        boot(32'h0000_1001, -1, 1'b0, 1);

        random_image(8);
        boot(32'd8, 2, 1'b0, 1);
        random_image(12);
        boot(32'd12, -1, 1'b0, 1);

`ifdef BOOT_CHECKSUM_EN
        img = {8'h01, 8'h02};
        boot(32'd2, -1, 1'b0, 1);
        boot(32'd2, -1, 1'b1, 1);
`endif

        for (int t = 0; t < 6; t++) begin
            n = $urandom_range(1, 40);
            random_image(n);
            boot(n, ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, n - 1)) : -1,
                 1'b0, $urandom_range(0, 3));
        end

        random_image(MAXB);
        boot(MAXB, -1, 1'b0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
